// File: rtl/br_trace_queue.sv
// Branch trace queue: buffers resolved-branch records between the stage-3 trace
// source and the predictor-update port, tagging each with its RAS operation.
module br_trace_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  logic [31:0]              enq_pc,
  input  logic [31:0]              enq_target,
  input  logic [1:0]               enq_br_type,
  input  logic                     enq_taken,
  input  logic [4:0]               enq_rs1,
  input  logic [4:0]               enq_rd,
  input  logic                     flush,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [31:0]              deq_pc,
  output logic [31:0]              deq_target,
  output logic [1:0]               deq_br_type,
  output logic                     deq_taken,
  output logic [1:0]               deq_ras_op,
  output logic [31:0]              trace_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  br_type;
    logic        taken;
    logic [1:0]  ras_op;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head_entry;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          eligible;
  logic          deq_fire;
  logic          enq_acc;
  logic          enq_drop;
  logic          full;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [1:0] ras_op_of(input logic [1:0] ty,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rd);
    logic [1:0] op;
    op = 2'b00;
    if (ty == 2'b10) begin
      op = is_link(rd) ? 2'b01 : 2'b00;
    end else if (ty == 2'b11) begin
      unique case ({is_link(rd), is_link(rs1)})
        2'b01:   op = 2'b10;
        2'b10:   op = 2'b01;
        2'b11:   op = (rs1 == rd) ? 2'b01 : 2'b11;
        default: op = 2'b00;
      endcase
    end
    return op;
  endfunction

  always_comb begin
    full      = (count == FULL_CNT);
    deq_valid = (count != '0);
    deq_fire  = deq_valid && deq_ready;
    eligible  = enq_valid && (enq_br_type != 2'b00) && !flush;
    enq_acc   = eligible && (!full || deq_fire);
    enq_drop  = eligible && full && !deq_fire;
  end

  // Outputs come only from stored head state; zeroed whenever the queue is empty.
  always_comb begin
    head_entry  = mem[head];
    deq_pc      = '0;
    deq_target  = '0;
    deq_br_type = '0;
    deq_taken   = 1'b0;
    deq_ras_op  = '0;
    if (deq_valid) begin
      deq_pc      = head_entry.pc;
      deq_target  = head_entry.target;
      deq_br_type = head_entry.br_type;
      deq_taken   = head_entry.taken;
      deq_ras_op  = head_entry.ras_op;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_acc) begin
      mem[tail] <= '{pc:      enq_pc,
                     target:  enq_target,
                     br_type: enq_br_type,
                     taken:   enq_taken,
                     ras_op:  ras_op_of(enq_br_type, enq_rs1, enq_rd)};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      trace_ptr <= '0;
      overflow  <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_acc) begin
        tail      <= tail + 1'b1;
        trace_ptr <= trace_ptr + 32'd1;
      end
      if (deq_fire) begin
        head <= head + 1'b1;
      end
      if (enq_drop) begin
        overflow <= 1'b1;
      end
      unique case ({enq_acc, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/br_trace_queue.md
BR_TRACE_QUEUE -- requirements
Module: br_trace_queue

Interface
REQ-001 Parameter: DEPTH, default 8, queue entries; power of two, at least 2.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enq_valid  input  1  resolved-branch record present this cycle (stage-3 valid).
REQ-005 enq_pc  input  32  branch PC.
REQ-006 enq_target  input  32  resolved target.
REQ-007 enq_br_type  input  2  00 none, 01 cond, 10 jal, 11 jalr.
REQ-008 enq_taken  input  1  resolved direction.
REQ-009 enq_rs1  input  5  source register.
REQ-010 enq_rd  input  5  destination register.
REQ-011 flush  input  1  synchronous queue clear.
REQ-012 deq_ready  input  1  predictor-update port accepts the head entry.
REQ-013 deq_valid  output  1  head entry valid.
REQ-014 deq_pc, deq_target  output  32 each  head PC and target.
REQ-015 deq_br_type  output  2  head type.
REQ-016 deq_taken  output  1  head direction.
REQ-017 deq_ras_op  output  2  00 none, 01 push, 10 pop, 11 pop-then-push.
REQ-018 trace_ptr  output  32  count of accepted records; drives the trace source's stage-3 pointer.
REQ-019 count  output  log2(DEPTH)+1  current occupancy.
REQ-020 overflow  output  1  sticky flag: a record was dropped.

Function
REQ-021 A record is accepted when enq_valid=1, enq_br_type!=00, flush=0, and (count<DEPTH or a dequeue fires the same cycle).
- A record with br_type=00 is discarded silently: no trace_ptr change, no overflow.
REQ-022 Each accepted record is written at the tail and increments trace_ptr by 1, modulo 2^32.
REQ-023 A dequeue fires when deq_valid=1 and deq_ready=1; the head pointer advances by 1.
REQ-024 deq_valid=1 exactly when count>0. Deq outputs are driven directly from head storage, with no combinational path from enq_* inputs.
REQ-025 Enqueue-to-dequeue latency is 1 cycle minimum: a record written into an empty queue appears on deq_* in the next cycle. There is no bypass.
REQ-026 Head and tail pointers wrap modulo DEPTH. count = previous count + accepted - dequeued.
REQ-027 Full with enq_valid and a dequeue in the same cycle: both complete, count stays DEPTH.
REQ-028 Full, eligible enq_valid, no dequeue: the record is dropped, overflow is set to 1, trace_ptr does not change.
REQ-029 Empty: deq_ready is ignored. Pointers and count do not change.
REQ-030 deq_ras_op is computed at enqueue and stored per entry; link(r) is true when r==1 or r==5:
- cond -> 00
- jal -> 01 if link(rd), else 00
- jalr, !link(rd) and link(rs1) -> 10
- jalr, link(rd) and !link(rs1) -> 01
- jalr, link(rd) and link(rs1) and rs1!=rd -> 11
- jalr, link(rd) and link(rs1) and rs1==rd -> 01
- jalr, neither link -> 00
REQ-031 flush=1 sets head, tail and count to 0 on the next edge. During a flush cycle:
- any enqueue or dequeue is discarded
- trace_ptr and overflow are unchanged.
REQ-032 When deq_valid=0, deq_pc, deq_target, deq_br_type, deq_taken and deq_ras_op shall all be 0.

Reset
REQ-033 While reset=0, immediately and without waiting for a clock edge:
- head, tail, count, trace_ptr, overflow = 0
- deq_valid = 0
- all deq_* outputs = 0.
REQ-034 Reset asserted mid-operation discards all queued entries. The first cycle after reset release behaves as an empty queue.
REQ-035 overflow is cleared only by reset.

Verification
REQ-036 Single jal: pc=0x80000000, target=0x80000100, rd=1, enqueued to empty queue -> next cycle deq_valid=1, deq_ras_op=01, trace_ptr=1.
REQ-037 Fill then overflow: 8 cond records with deq_ready=0 -> count=8. A 9th record -> overflow=1, trace_ptr=8, count=8.
REQ-038 Full queue, enq_valid=1 and deq_ready=1 in the same cycle -> count stays 8, trace_ptr increments, FIFO order preserved across pointer wrap.
REQ-039 jalr ras_op table: (rs1,rd) = (1,0)->10, (0,5)->01, (5,1)->11, (1,1)->01, (2,3)->00.
REQ-040 Flush with 3 entries queued and enq_valid=1 -> count=0 next cycle, trace_ptr unchanged, enqueued record absent.
REQ-041 reset driven low mid-stream with 4 entries queued -> deq_valid=0 immediately; after release, count=0, trace_ptr=0, overflow=0.
